sync_fifo_param: RTL

Parametrised single-clock FIFO: successor to the fixed 36x1024 sync FIFO configurations, generalised in data width and depth. Adds selectable standard/first-word-fall-through read mode, programmable empty/full watermarks and an occupancy count output. It is the common synchronous buffer used between datapath stages and serves as the RTL golden model for mapped sync FIFO primitives.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_flags.sv | 62 ++++++
 rtl/sync_fifo_param.sv | 98 +++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy must be able to represent the full value DEPTH, not only DEPTH-1.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int dw, input int depth, input int fwft,
                                      input int pe, input int pf);
    return (dw >= 1) && (dw <= 72) && (depth >= 4) && (depth <= 4096) &&
           ((fwft == FIFO_STD) || (fwft == FIFO_FWFT)) &&
           (pe >= 1) && (pe < pf) && (pf <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flags.sv
// Occupancy counter plus the eight status registers, all decoded from the next count.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int PROG_EMPTY = 4,
  parameter int PROG_FULL  = DEPTH - 4,
  parameter int CW         = count_width(DEPTH)
) (
  input  logic          clock0,
  input  logic          rst_ptr,
  input  logic          wr_acc,
  input  logic          rd_acc,
  input  logic          wr_rej,
  input  logic          rd_rej,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          epo,
  output logic          ewm,
  output logic          full,
  output logic          fmo,
  output logic          fwm,
  output logic          underrun,
  output logic          overrun
);

  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clock0) begin
    if (rst_ptr) begin
      count    <= '0;
      empty    <= 1'b1;
      epo      <= 1'b0;
      ewm      <= 1'b1;
      full     <= 1'b0;
      fmo      <= 1'b0;
      fwm      <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      count    <= count_next;
      empty    <= (count_next == '0);
      epo      <= (count_next == CW'(1));
      ewm      <= (count_next <= CW'(PROG_EMPTY));
      full     <= (count_next == CW'(DEPTH));
      fmo      <= (count_next == CW'(DEPTH - 1));
      fwm      <= (count_next >= CW'(PROG_FULL));
      underrun <= rd_rej;
      overrun  <= wr_rej;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, storage and read-data path; status lives in sync_fifo_flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 1024,
  parameter int FWFT       = 0,
  parameter int PROG_EMPTY = 4,
  parameter int PROG_FULL  = DEPTH - 4
) (
  input  logic                          clock0,
  input  logic                          rst_ptr,
  input  logic                          we,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          re,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          EMPTY,
  output logic                          EPO,
  output logic                          EWM,
  output logic                          FULL,
  output logic                          FMO,
  output logic                          FWM,
  output logic                          UNDERRUN,
  output logic                          OVERRUN
);

  localparam int AW = $clog2(DEPTH);

  if (!params_legal(DATA_WIDTH, DEPTH, FWFT, PROG_EMPTY, PROG_FULL)) begin : g_bad_params
    $error("sync_fifo_param: illegal parameter combination");
  end

  // we/re are requests sampled on each rising edge; a request is taken only when the
  // registered FULL/EMPTY allows it, otherwise it is dropped and OVERRUN/UNDERRUN pulses next cycle.
  logic          wr_acc, rd_acc, wr_rej, rd_rej;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign wr_acc = we && !FULL  && !rst_ptr;
  assign rd_acc = re && !EMPTY && !rst_ptr;
  assign wr_rej = we && FULL   && !rst_ptr;
  assign rd_rej = re && EMPTY  && !rst_ptr;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock0) begin
    if (rst_ptr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clock0) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout = mem[rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clock0) begin
      if (rst_ptr)     dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr];
    end
    assign dout = dout_q;
  end

  sync_fifo_flags #(
    .DEPTH      (DEPTH),
    .PROG_EMPTY (PROG_EMPTY),
    .PROG_FULL  (PROG_FULL),
    .CW         (count_width(DEPTH))
  ) u_flags (
    .clock0   (clock0),
    .rst_ptr  (rst_ptr),
    .wr_acc   (wr_acc),
    .rd_acc   (rd_acc),
    .wr_rej   (wr_rej),
    .rd_rej   (rd_rej),
    .count    (count),
    .empty    (EMPTY),
    .epo      (EPO),
    .ewm      (EWM),
    .full     (FULL),
    .fmo      (FMO),
    .fwm      (FWM),
    .underrun (UNDERRUN),
    .overrun  (OVERRUN)
  );

endmodule
